// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between a single-cycle datapath and a valid/ready data-memory bus.
// A memory request from the datapath is turned into one bus transaction; stall stays high
// until the access completes so the PC and register write are frozen. Load data comes back
// lane-selected and sign/zero-extended on rdata during the completion (DONE) cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_read, mem_write   request strobes from control (both high = write)
//   size, load_unsigned   access size (00 byte, 01 half, 1x word), zero-extend loads
//   addr, wdata           byte address and store data from the datapath
//   rdata                 load result, held outside the completion cycle
//   stall                 freeze PC / suppress RegWrite
//   misalign_err, bus_err one-cycle error pulses in the completion cycle
//   bus_req_*             request channel (valid/ready, we, word address, wdata, be)
//   bus_rsp_*             response channel (valid strobe, data, err)
module lsu_bus_bridge #(
  parameter int unsigned nbit    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  input  logic [nbit-1:0] addr,
  input  logic [nbit-1:0] wdata,
  output logic [nbit-1:0] rdata,
  output logic            stall,
  output logic            misalign_err,
  output logic            bus_err,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_req_we,
  output logic [nbit-1:0] bus_req_addr,
  output logic [nbit-1:0] bus_req_wdata,
  output logic [3:0]      bus_req_be,
  input  logic            bus_rsp_valid,
  input  logic [nbit-1:0] bus_rsp_data,
  input  logic            bus_rsp_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      lane_q;
  logic [1:0]      size_q;
  logic            uns_q;

  logic            req;
  logic            aligned;
  logic            tmo;
  logic [3:0]      be_calc;
  logic [nbit-1:0] wdata_calc;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [nbit-1:0] load_val;

  assign req = mem_read | mem_write;
  // Last permitted REQ/WAIT cycle: REQ+WAIT together last at most TIMEOUT cycles.
  assign tmo = (cnt_q == CntW'(TIMEOUT - 1));

  // Alignment, byte enables and lane-replicated store data, all from the live request.
  always_comb begin
    aligned    = 1'b1;
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    unique case (size)
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned    = ~addr[0];
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Little-endian lane extraction from the response word.
  always_comb begin
    byte_sel = bus_rsp_data[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? bus_rsp_data[31:16] : bus_rsp_data[15:0];
    load_val = bus_rsp_data;
    unique case (size_q)
      2'b00: load_val = uns_q ? {{(nbit-8){1'b0}}, byte_sel}
                              : {{(nbit-8){byte_sel[7]}}, byte_sel};
      2'b01: load_val = uns_q ? {{(nbit-16){1'b0}}, half_sel}
                              : {{(nbit-16){half_sel[15]}}, half_sel};
      default: load_val = bus_rsp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    bus_req_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          // Misaligned requests skip the bus and complete through DONE to pulse the error.
          state_d = aligned ? StReq : StDone;
          stall   = aligned;
        end
      end
      StReq: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        // Timeout wins over a same-cycle handshake so REQ+WAIT never exceeds TIMEOUT.
        if (tmo)                state_d = StDone;
        else if (bus_req_ready) state_d = StWait;
      end
      StWait: begin
        stall = 1'b1;
        if (bus_rsp_valid || tmo) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      lane_q        <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      rdata         <= '0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_be    <= '0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req && aligned) begin
            cnt_q         <= '0;
            lane_q        <= addr[1:0];
            size_q        <= size;
            uns_q         <= load_unsigned;
            bus_req_we    <= mem_write;
            bus_req_addr  <= {addr[nbit-1:2], 2'b00};
            bus_req_wdata <= wdata_calc;
            bus_req_be    <= be_calc;
          end else if (req) begin
            misalign_err <= 1'b1;
            rdata        <= '0;
          end
        end
        StReq: begin
          cnt_q <= cnt_q + CntW'(1);
          if (tmo) begin
            bus_err <= 1'b1;
            rdata   <= '0;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (bus_rsp_valid) begin
            bus_err <= bus_rsp_err;
            rdata   <= (bus_rsp_err || bus_req_we) ? '0 : load_val;
          end else if (tmo) begin
            bus_err <= 1'b1;
            rdata   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_bus_bridge.md
# lsu_bus_bridge

Load/store bridge between the single-cycle datapath and a valid/ready data-memory bus. It takes the datapath's memory request (ALU result as address, register read data as store data, plus control strobes), runs a multi-cycle bus transaction, and holds `stall` high so the program counter and register-file write are frozen until the access completes. It returns load data to the datapath's `ReadData` input with byte/halfword selection and sign/zero extension, and flags misaligned and failed accesses.

## Interface
- `nbit`, 32, data/address width (block supports 32 only)
- `TIMEOUT`, 16, max cycles in REQ+WAIT before forced error completion (≥2)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_read`  in  1  load request from control
- `mem_write`  in  1  store request from control
- `size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `load_unsigned`  in  1  1 = zero-extend byte/half loads
- `addr`  in  nbit  byte address (ALU result)
- `wdata`  in  nbit  store data (register RD2)
- `rdata`  out  nbit  load result to datapath ReadData
- `stall`  out  1  1 = freeze PC and suppress RegWrite this cycle
- `misalign_err`  out  1  one-cycle pulse, misaligned access dropped
- `bus_err`  out  1  one-cycle pulse, bus error or timeout
- `bus_req_valid` / `bus_req_ready`  out / in  1  request handshake
- `bus_req_we`  out  1  1 = write
- `bus_req_addr`  out  nbit  word-aligned address (`addr[31:2]`,2'b00)
- `bus_req_wdata`  out  nbit  lane-replicated store data
- `bus_req_be`  out  4  byte enables
- `bus_rsp_valid`  in  1  response/ack strobe (no ready; always accepted in WAIT)
- `bus_rsp_data`  in  nbit  read data word
- `bus_rsp_err`  in  1  qualifies `bus_rsp_valid`

## Operation
- States: IDLE, REQ, WAIT, DONE. `req = mem_read | mem_write`; both high = write.
- IDLE, `req`, aligned: capture addr/we/be/wdata/size/unsigned into registers, go REQ. Misaligned (half with `addr[0]`, word with `addr[1:0]!=0`): no bus activity, `misalign_err`=1 next cycle, state stays IDLE via DONE (see Timing), store suppressed, `rdata`=0.
- REQ: `bus_req_valid`=1 from registers, stable until `bus_req_ready`; on handshake go WAIT.
- WAIT: on `bus_rsp_valid` go DONE; latch `rdata` (load) from `bus_rsp_data`; if `bus_rsp_err`, `bus_err`=1 and `rdata`=0.
- Timeout counter clears on entering REQ, counts each REQ/WAIT cycle; at `TIMEOUT` go DONE with `bus_err`=1, `rdata`=0, `bus_req_valid` dropped.
- DONE: one cycle, `stall`=0, then IDLE. DONE never starts a new access (the instruction is completing; PC advances at end of DONE).
- Byte enables / store lanes: byte `be = 1<<addr[1:0]`, wdata = {4{wdata[7:0]}}; half `be = addr[1]?1100:0011`, wdata = {2{wdata[15:0]}}; word `be=1111`, wdata unchanged.
- Load extract (little-endian): byte lane `addr[1:0]`, half lane `addr[1]`; sign-extend unless `load_unsigned`. Stores return `rdata`=0.
- `bus_rsp_valid` outside WAIT is ignored.

## Timing
- `stall = (IDLE & req & aligned) | REQ | WAIT`; combinational from inputs in IDLE, otherwise from state.
- Minimum access: cycle 0 request seen (stall=1), cycle 1 REQ with ready, cycle 2 WAIT with rsp_valid, cycle 3 DONE (stall=0, `rdata` valid). Four cycles per memory instruction; non-memory instructions add none.
- Misaligned: cycle 0 request, stall=0, cycle 1 `misalign_err`=1 registered pulse. Error pulses are valid in the DONE-equivalent cycle only.
- `rdata` holds its last value outside DONE.
- Reset: state IDLE, counter 0, all outputs 0 (`bus_req_valid`, `stall`, errors, `rdata`, be, addr, wdata). Reset mid-transaction abandons it at the same edge; a late response after reset is ignored.

## Test plan
- Word load `addr=0x100`, bus ready immediately, rsp `0xDEADBEEF` next cycle -> stall high 3 cycles, `bus_req_addr=0x100`, `be=1111`, DONE `rdata=0xDEADBEEF`.
- Byte store `addr=0x103`, `wdata=0x000000A5` -> `be=1000`, `bus_req_wdata=0xA5A5A5A5`, `we=1`; signed byte load of `0x80` lane 3 -> `rdata=0xFFFFFF80`, unsigned -> `0x00000080`.
- Half load `addr=0x102`, rsp `0x8001_1234` -> signed `0xFFFF8001`; half load `addr=0x101` -> no `bus_req_valid`, `misalign_err` one pulse, stall never high.
- `bus_req_ready` low 5 cycles, then rsp with `bus_rsp_err=1` -> request fields stable throughout, `bus_err` pulse, `rdata=0`; `TIMEOUT=16` with no rsp -> DONE at cycle 16 of REQ+WAIT, `bus_err`=1.
- `reset` asserted in WAIT, rsp arrives next cycle -> all outputs 0, rsp ignored, next request starts cleanly from IDLE.
